// File: rtl/bootram_loader_pkg.sv
// Shared types and constants for the boot RAM loader: FSM states and frame framing constants.
package bootram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         HDR_LEN   = 4;

    // States in which a frame is being received and bytes are accepted.
    function automatic logic is_busy(state_t s);
        return (s == ST_SYNC) || (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/bootram_loader_if.sv
// Byte stream input and RAM write port of the boot RAM loader, bundled as one interface.
interface bootram_loader_if #(
    parameter int DATA = 32,
    parameter int ADDR = 12
);
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic            ram_ce;
    logic            ram_we;
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_write;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, ram_ce, ram_we, ram_addr, ram_write
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, ram_ce, ram_we, ram_addr, ram_write
    );
endinterface

// File: rtl/bootram_loader_asm.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k], and the
// finished word is copied to a holding register with a one-cycle ready pulse.
module bootram_loader_asm #(
    parameter int DATA = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            push,
    input  logic [7:0]      push_byte,
    output logic            last_lane,
    output logic            word_ready,
    output logic [DATA-1:0] word
);
    localparam int BYTES = DATA / 8;
    localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [LW-1:0]   lane_reg;
    logic [DATA-1:0] shift_reg;
    logic [DATA-1:0] shift_next;
    logic [DATA-1:0] word_reg;
    logic            word_ready_reg;

    assign last_lane  = (lane_reg == LW'(BYTES - 1));
    assign word_ready = word_ready_reg;
    assign word       = word_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign shift_next[8*gi +: 8] = (lane_reg == LW'(gi)) ? push_byte : shift_reg[8*gi +: 8];
        end
    endgenerate

    // The holding register frees the shift register, so the next word can start while
    // the previous one is being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_reg       <= '0;
            shift_reg      <= '0;
            word_reg       <= '0;
            word_ready_reg <= 1'b0;
        end else begin
            word_ready_reg <= push && last_lane;
            if (clr) begin
                lane_reg <= '0;
            end else if (push) begin
                shift_reg <= shift_next;
                if (last_lane) begin
                    lane_reg <= '0;
                    word_reg <= shift_next;
                end else begin
                    lane_reg <= lane_reg + LW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bootram_loader.sv
// Boot RAM loader: parses a framed byte stream, writes assembled words to RAM and holds the
// CPU in reset until a frame with a good checksum has been loaded.
module bootram_loader
    import bootram_loader_pkg::*;
#(
    parameter int DATA    = 32,
    parameter int ADDR    = 12,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    bootram_loader_if.master  bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state_reg;
    logic [1:0]      hdr_idx_reg;
    logic [7:0]      base_lo_reg;
    logic [15:0]     cnt_reg;
    logic [7:0]      sum_reg;
    logic [TW-1:0]   tmo_reg;
    logic [ADDR-1:0] waddr_reg;
    logic [ADDR-1:0] addr_reg;

    logic            accept;
    logic            tmo_hit;
    logic            last_lane;
    logic            word_ready;
    logic [DATA-1:0] word;
    logic [7:0]      sum_next;

    assign accept   = bus.rx_valid && bus.rx_ready;
    assign sum_next = sum_reg + bus.rx_data;
    assign tmo_hit  = (TIMEOUT != 0) && !accept && (32'(tmo_reg) == 32'(TIMEOUT - 1));

    bootram_loader_asm #(.DATA(DATA)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (state_reg != ST_DATA),
        .push       (accept && (state_reg == ST_DATA)),
        .push_byte  (bus.rx_data),
        .last_lane  (last_lane),
        .word_ready (word_ready),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            hdr_idx_reg <= '0;
            base_lo_reg <= '0;
            cnt_reg     <= '0;
            sum_reg     <= '0;
            tmo_reg     <= '0;
            waddr_reg   <= '0;
            addr_reg    <= '0;
        end else begin
            // Idle-gap watchdog; SYNC is excluded so the loader can wait forever for a frame.
            if ((state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_CHK)) begin
                if (accept)       tmo_reg   <= '0;
                else if (tmo_hit) state_reg <= ST_ERR;
                else              tmo_reg   <= tmo_reg + TW'(1);
            end

            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_reg <= ST_SYNC;
                        tmo_reg   <= '0;
                    end
                end
                ST_SYNC: begin
                    if (accept && (bus.rx_data == SYNC_BYTE)) begin
                        state_reg   <= ST_HDR;
                        hdr_idx_reg <= '0;
                        sum_reg     <= '0;
                        tmo_reg     <= '0;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        sum_reg     <= sum_next;
                        hdr_idx_reg <= hdr_idx_reg + 2'd1;
                        case (hdr_idx_reg)
                            2'd0:    base_lo_reg <= bus.rx_data;
                            2'd1:    waddr_reg   <= ADDR'({bus.rx_data, base_lo_reg});
                            2'd2:    cnt_reg[7:0] <= bus.rx_data;
                            default: cnt_reg[15:8] <= bus.rx_data;
                        endcase
                        if (hdr_idx_reg == 2'(HDR_LEN - 1)) begin
                            state_reg <= ({bus.rx_data, cnt_reg[7:0]} == 16'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        sum_reg <= sum_next;
                        if (last_lane) begin
                            addr_reg  <= waddr_reg;
                            waddr_reg <= waddr_reg + ADDR'(1);
                            cnt_reg   <= cnt_reg - 16'd1;
                            if (cnt_reg == 16'd1) state_reg <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        sum_reg   <= sum_next;
                        state_reg <= (sum_next == 8'h00) ? ST_DONE : ST_ERR;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = is_busy(state_reg);
    assign bus.ram_we    = word_ready;
    assign bus.ram_ce    = word_ready;
    assign bus.ram_addr  = addr_reg;
    assign bus.ram_write = word;
    assign busy          = is_busy(state_reg);
    assign cpu_hold      = (state_reg != ST_DONE);
    assign done          = (state_reg == ST_DONE);
    assign error         = (state_reg == ST_ERR);

endmodule

// File: tb/tb_bootram_loader.sv
// Directed bench for bootram_loader: frame loads, bad checksum, sync hunting, address
// wrap, timeout and mid-frame reset.
module tb_bootram_loader;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold, busy, done, error;

    int n_checks = 0;
    int n_fail   = 0;
    int ce_bad   = 0;

    logic [11:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [7:0]  frame_q [$];
    logic [31:0] words_q [$];

    bootram_loader_if #(.DATA(32), .ADDR(12)) bus ();

    bootram_loader #(.DATA(32), .ADDR(12), .TIMEOUT(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wr_addr.push_back(bus.ram_addr);
            wr_data.push_back(bus.ram_write);
            $display("write addr=%03h data=%08h", bus.ram_addr, bus.ram_write);
        end
        if (bus.ram_ce !== bus.ram_we) ce_bad++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte: rx_ready=%b required 1 within 50 cycles", bus.rx_ready);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        $display("byte %02h accepted", b);
    endtask

    task automatic pulse_start();
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_arm: busy=%b rx_ready=%b required 1 1", busy, bus.rx_ready);
        end
    endtask

    task automatic build_frame(input logic [15:0] base, input logic [7:0] adj);
        logic [7:0]  s;
        logic [15:0] cnt;
        logic [31:0] w;
        cnt = 16'(words_q.size());
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(base[7:0]);
        frame_q.push_back(base[15:8]);
        frame_q.push_back(cnt[7:0]);
        frame_q.push_back(cnt[15:8]);
        foreach (words_q[i]) begin
            w = words_q[i];
            for (int k = 0; k < 4; k++) frame_q.push_back(w[8*k +: 8]);
        end
        s = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
        frame_q.push_back(8'h00 - s + adj);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.rx_ready, cpu_hold, busy, done, error, bus.ram_we, bus.ram_ce} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/hold/busy/done/err/we/ce=%b required 0100000",
                     {bus.rx_ready, cpu_hold, busy, done, error, bus.ram_we, bus.ram_ce});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: rx_ready=%b cpu_hold=%b required 0 1", bus.rx_ready, cpu_hold);
        end
    endtask

    task automatic test_good_frame(input logic bad_chk);
        logic [7:0] t [14];
        t = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        if (bad_chk) t[13] = 8'h9A;
        pulse_start();
        for (int i = 0; i < 14; i++) begin
            send_byte(t[i]);
            if (i == 8) begin
                n_checks++;
                if (bus.ram_we !== 1'b1 || bus.ram_ce !== 1'b1 || bus.ram_addr !== 12'h100 || bus.ram_write !== 32'h44332211) begin
                    n_fail++;
                    $display("FAIL word0_latency: we=%b ce=%b addr=%03h data=%08h required 1 1 100 44332211",
                             bus.ram_we, bus.ram_ce, bus.ram_addr, bus.ram_write);
                end
            end
            if (i == 12) begin
                n_checks++;
                if (bus.ram_we !== 1'b1 || bus.ram_addr !== 12'h101 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL word1_latency: we=%b addr=%03h hold=%b busy=%b required 1 101 1 1",
                             bus.ram_we, bus.ram_addr, cpu_hold, busy);
                end
            end
        end
        n_checks++;
        if (cpu_hold !== bad_chk || done !== !bad_chk || error !== bad_chk || busy !== 1'b0 || bus.rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_result: hold=%b done=%b err=%b busy=%b rdy=%b required %b %b %b 0 0",
                     cpu_hold, done, error, busy, bus.rx_ready, bad_chk, !bad_chk, bad_chk);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_addr.size() != 2 || wr_data.size() != 2) begin
            n_fail++;
            $display("FAIL frame_writes: count=%0d required 2", wr_addr.size());
        end else if (wr_addr[0] !== 12'h100 || wr_data[0] !== 32'h44332211 ||
                     wr_addr[1] !== 12'h101 || wr_data[1] !== 32'h88776655) begin
            n_fail++;
            $display("FAIL frame_writes: %03h=%08h %03h=%08h required 100=44332211 101=88776655",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic test_sync_hunt();
        logic [7:0] t [9];
        t = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'hF0};
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(t[i]);
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_hunt: done=%b err=%b writes=%0d hold=%b required 1 0 0 0",
                     done, error, wr_addr.size(), cpu_hold);
        end
    endtask

    task automatic test_addr_wrap();
        words_q = '{32'hDEADBEEF, 32'h01234567};
        build_frame(16'hFFFF, 8'h00);
        pulse_start();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_addr.size() != 2 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_wrap_count: writes=%0d done=%b required 2 1", wr_addr.size(), done);
        end else if (wr_addr[0] !== 12'hFFF || wr_addr[1] !== 12'h000 ||
                     wr_data[0] !== 32'hDEADBEEF || wr_data[1] !== 32'h01234567) begin
            n_fail++;
            $display("FAIL addr_wrap: %03h=%08h %03h=%08h required FFF=DEADBEEF 000=01234567",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] t [8];
        t = '{8'hA5, 8'h20, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(t[i]);
        repeat (10) @(negedge clk);
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: error=%b busy=%b required 0 1", error, busy);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1 || bus.rx_ready !== 1'b0 || wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: err=%b busy=%b hold=%b rdy=%b writes=%0d required 1 0 1 0 0",
                     error, busy, cpu_hold, bus.rx_ready, wr_addr.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] t [7];
        t = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h00, 8'hAA, 8'hBB};
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(t[i]);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.rx_ready !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0 || wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL reset_midframe: rdy=%b hold=%b busy=%b writes=%0d required 0 1 0 0",
                     bus.rx_ready, cpu_hold, busy, wr_addr.size());
        end
        words_q = '{32'hCAFEF00D};
        build_frame(16'h0200, 8'h00);
        pulse_start();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || wr_addr.size() != 1) begin
            n_fail++;
            $display("FAIL reload_after_reset: done=%b writes=%0d required 1 1", done, wr_addr.size());
        end else if (wr_addr[0] !== 12'h200 || wr_data[0] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL reload_write: %03h=%08h required 200=CAFEF00D", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_ce_tracks_we();
        n_checks++;
        if (ce_bad != 0) begin
            n_fail++;
            $display("FAIL ce_equals_we: mismatched cycles=%0d required 0", ce_bad);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame(1'b0);
        test_good_frame(1'b1);
        test_sync_hunt();
        test_addr_wrap();
        test_timeout();
        test_reset_midframe();
        test_ce_tracks_we();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
